// File: rtl/lsu_ram_master.sv
// Load/store bus initiator for a single-port data RAM with registered read data.
// Optional build macro LSU_RANGE_CHK_EN rejects word indices >= MEM_DEPTH.
module lsu_ram_master #(
    parameter int MEM_DEPTH = 51
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        cs,
    output logic        rd,
    output logic        wr,
    output logic [31:0] address,
    output logic [31:0] DB_w,
    input  logic [31:0] DB_r
);

    typedef enum logic [2:0] {IDLE, RD, RD_CAP, WR, MRG, RESP} state_t;

    state_t      state, state_nxt;
    logic        we_p0;
    logic [1:0]  size_p0;
    logic        uns_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;

    logic        req_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic        cs_nxt, rd_nxt, wr_nxt;
    logic [31:0] rsp_rdata_nxt, address_nxt, db_w_nxt;
    logic        range_err, req_err;

    if (MEM_DEPTH < 1) begin : g_depth_invalid
        $error("lsu_ram_master: MEM_DEPTH must be at least 1");
    end

`ifdef LSU_RANGE_CHK_EN
    assign range_err = ({2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH));
`else
    assign range_err = 1'b0;
`endif

    assign req_err = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || range_err;

    function automatic logic [31:0] load_align(input logic [31:0] data, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        lane_b = data[{off, 3'b000} +: 8];
        lane_h = data[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   load_align = uns ? {24'b0, lane_b} : 32'(lane_b);
            2'b01:   load_align = uns ? {16'b0, lane_h} : 32'(lane_h);
            default: load_align = data;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
        merge_lane = old;
        case (size)
            2'b00:   merge_lane[{off, 3'b000} +: 8] = wdata[7:0];
            2'b01:   merge_lane[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: merge_lane = wdata;
        endcase
    endfunction

    // Next-state and next-output decode; every bus/response output is registered
    always_comb begin
        state_nxt     = state;
        cs_nxt        = 1'b0;
        rd_nxt        = 1'b0;
        wr_nxt        = 1'b0;
        address_nxt   = 32'b0;
        db_w_nxt      = 32'b0;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = 32'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                    end else if (req_we && req_size == 2'b10) begin
                        state_nxt   = WR;
                        cs_nxt      = 1'b1;
                        wr_nxt      = 1'b1;
                        address_nxt = {2'b00, req_addr[31:2]};
                        db_w_nxt    = req_wdata;
                    end else begin
                        state_nxt   = RD;
                        cs_nxt      = 1'b1;
                        rd_nxt      = 1'b1;
                        address_nxt = {2'b00, req_addr[31:2]};
                    end
                end
            end
            RD:     state_nxt = we_p0 ? MRG : RD_CAP;
            RD_CAP: begin
                state_nxt     = RESP;
                rsp_valid_nxt = 1'b1;
                rsp_rdata_nxt = load_align(DB_r, size_p0, addr_p0[1:0], uns_p0);
            end
            MRG: begin
                state_nxt   = WR;
                cs_nxt      = 1'b1;
                wr_nxt      = 1'b1;
                address_nxt = {2'b00, addr_p0[31:2]};
                db_w_nxt    = merge_lane(DB_r, wdata_p0, size_p0, addr_p0[1:0]);
            end
            WR: begin
                state_nxt     = RESP;
                rsp_valid_nxt = 1'b1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        req_ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'b0;
            cs        <= 1'b0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            address   <= 32'b0;
            DB_w      <= 32'b0;
        end else begin
            state     <= state_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            cs        <= cs_nxt;
            rd        <= rd_nxt;
            wr        <= wr_nxt;
            address   <= address_nxt;
            DB_w      <= db_w_nxt;
        end
    end

    // Request capture at the accept edge
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            we_p0    <= req_we;
            size_p0  <= req_size;
            uns_p0   <= req_unsigned;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed self-checking bench for lsu_ram_master with a registered-read RAM model.
module tb_lsu_ram_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        cs, rd, wr;
    logic [31:0] address, DB_w, DB_r;

    logic [31:0] mem [0:63];

    int passed = 0;
    int total  = 0;

    int          w_rsp_cnt, w_rsp_cyc, w_cs_cnt, w_rd_cyc, w_wr_cyc, w_wr_cnt;
    logic [31:0] w_rsp_data, w_wr_addr, w_wr_data;
    logic        w_rsp_err, w_overlap, w_accept, w_busy_ready;

    always #5 clk = ~clk;

    lsu_ram_master #(.MEM_DEPTH(51)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .cs(cs), .rd(rd), .wr(wr), .address(address),
        .DB_w(DB_w), .DB_r(DB_r)
    );

    always @(posedge clk) begin
        if (cs && rd) DB_r <= mem[address[5:0]];
        if (cs && wr) mem[address[5:0]] <= DB_w;
    end

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        w_rsp_cnt = 0; w_rsp_cyc = -1; w_cs_cnt = 0; w_rd_cyc = -1; w_wr_cyc = -1; w_wr_cnt = 0;
        w_rsp_data = 32'hxxxx_xxxx; w_rsp_err = 1'bx; w_wr_addr = 32'hxxxx_xxxx;
        w_wr_data = 32'hxxxx_xxxx; w_overlap = 1'b0; w_busy_ready = 1'b0;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        w_accept = req_ready;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1 && req_ready) w_busy_ready = 1'b1;
            if (rd && wr) w_overlap = 1'b1;
            if (cs) w_cs_cnt++;
            if (cs && rd && w_rd_cyc < 0) w_rd_cyc = c;
            if (cs && wr) begin
                w_wr_cnt++;
                w_wr_cyc  = c;
                w_wr_addr = address;
                w_wr_data = DB_w;
            end
            if (rsp_valid) begin
                w_rsp_cnt++;
                if (w_rsp_cyc < 0) begin
                    w_rsp_cyc  = c;
                    w_rsp_data = rsp_rdata;
                    w_rsp_err  = rsp_err;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'b0; req_wdata = 32'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", req_ready); else passed++;
        total++;
        if ({rsp_valid, rsp_err, cs, rd, wr} !== 5'b0)
            $display("FAIL reset_ctrl got=%b want=00000", {rsp_valid, rsp_err, cs, rd, wr});
        else passed++;
        total++;
        if ({rsp_rdata, address, DB_w} !== 96'b0)
            $display("FAIL reset_data rdata=%h addr=%h dbw=%h want=0", rsp_rdata, address, DB_w);
        else passed++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || cs !== 1'b0)
            $display("FAIL idle_after_reset ready=%b cs=%b want=1/0", req_ready, cs);
        else passed++;
    endtask

    task automatic test_word_store_load;
        run_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h8081_82F3);
        total++;
        if (w_accept !== 1'b1 || w_busy_ready !== 1'b0)
            $display("FAIL wst_handshake accept=%b busy_ready=%b want=1/0", w_accept, w_busy_ready);
        else passed++;
        total++;
        if (w_wr_cyc != 1 || w_wr_addr !== 32'd2 || w_wr_data !== 32'h8081_82F3 || w_rd_cyc != -1)
            $display("FAIL wst_bus wr_cyc=%0d addr=%h data=%h rd_cyc=%0d want=1/2/808182f3/-1",
                     w_wr_cyc, w_wr_addr, w_wr_data, w_rd_cyc);
        else passed++;
        total++;
        if (w_rsp_cyc != 2 || w_rsp_cnt != 1 || w_rsp_err !== 1'b0 || w_rsp_data !== 32'h0)
            $display("FAIL wst_rsp cyc=%0d cnt=%0d err=%b data=%h want=2/1/0/0",
                     w_rsp_cyc, w_rsp_cnt, w_rsp_err, w_rsp_data);
        else passed++;
        run_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        total++;
        if (w_rd_cyc != 1 || w_wr_cnt != 0 || w_cs_cnt != 1)
            $display("FAIL wld_bus rd_cyc=%0d wr_cnt=%0d cs_cnt=%0d want=1/0/1", w_rd_cyc, w_wr_cnt, w_cs_cnt);
        else passed++;
        total++;
        if (w_rsp_cyc != 3 || w_rsp_data !== 32'h8081_82F3 || w_rsp_err !== 1'b0)
            $display("FAIL wld_rsp cyc=%0d data=%h err=%b want=3/808182f3/0", w_rsp_cyc, w_rsp_data, w_rsp_err);
        else passed++;
    endtask

    task automatic test_subword_loads;
        run_req(1'b0, 2'b00, 1'b0, 32'h8, 32'h0);
        total++;
        if (w_rsp_cyc != 3 || w_rsp_data !== 32'hFFFF_FFF3)
            $display("FAIL ldb_signed cyc=%0d data=%h want=3/fffffff3", w_rsp_cyc, w_rsp_data);
        else passed++;
        run_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
        total++;
        if (w_rsp_cyc != 3 || w_rsp_data !== 32'h0000_0082)
            $display("FAIL ldb_unsigned cyc=%0d data=%h want=3/00000082", w_rsp_cyc, w_rsp_data);
        else passed++;
        run_req(1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
        total++;
        if (w_rsp_cyc != 3 || w_rsp_data !== 32'hFFFF_8081)
            $display("FAIL ldh_signed cyc=%0d data=%h want=3/ffff8081", w_rsp_cyc, w_rsp_data);
        else passed++;
    endtask

    task automatic test_byte_store;
        run_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_005A);
        total++;
        if (w_rd_cyc != 1 || w_wr_cyc != 3 || w_wr_addr !== 32'd2 || w_wr_data !== 32'h8081_5AF3)
            $display("FAIL stb_bus rd_cyc=%0d wr_cyc=%0d addr=%h data=%h want=1/3/2/80815af3",
                     w_rd_cyc, w_wr_cyc, w_wr_addr, w_wr_data);
        else passed++;
        total++;
        if (w_rsp_cyc != 4 || w_rsp_cnt != 1 || w_overlap !== 1'b0 || w_rsp_err !== 1'b0)
            $display("FAIL stb_rsp cyc=%0d cnt=%0d overlap=%b err=%b want=4/1/0/0",
                     w_rsp_cyc, w_rsp_cnt, w_overlap, w_rsp_err);
        else passed++;
        run_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        total++;
        if (w_rsp_data !== 32'h8081_5AF3)
            $display("FAIL stb_readback got=%h want=80815af3", w_rsp_data);
        else passed++;
    endtask

    task automatic test_half_store;
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_1234);
        total++;
        if (w_wr_cyc != 3 || w_wr_addr !== 32'd4 || w_wr_data !== 32'h1234_BEEF)
            $display("FAIL sth_bus wr_cyc=%0d addr=%h data=%h want=3/4/1234beef", w_wr_cyc, w_wr_addr, w_wr_data);
        else passed++;
        run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        total++;
        if (w_rsp_data !== 32'h0000_1234)
            $display("FAIL ldh_unsigned got=%h want=00001234", w_rsp_data);
        else passed++;
        run_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        total++;
        if (w_rsp_data !== 32'hFFFF_BEEF)
            $display("FAIL ldh_low_signed got=%h want=ffffbeef", w_rsp_data);
        else passed++;
        run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        total++;
        if (w_rsp_data !== 32'h0000_0012)
            $display("FAIL ldb_lane3 got=%h want=00000012", w_rsp_data);
        else passed++;
    endtask

    task automatic test_errors;
        logic [1:0]  sizes [3];
        logic [31:0] addrs [3];
        sizes = '{2'b10, 2'b01, 2'b11};
        addrs = '{32'h6, 32'h5, 32'h8};
        for (int i = 0; i < 3; i++) begin
            run_req(1'b0, sizes[i], 1'b0, addrs[i], 32'h0);
            total++;
            if (w_rsp_cyc != 1 || w_rsp_err !== 1'b1 || w_rsp_data !== 32'h0 || w_cs_cnt != 0 || w_rsp_cnt != 1)
                $display("FAIL err_case%0d cyc=%0d err=%b data=%h cs_cnt=%0d cnt=%0d want=1/1/0/0/1",
                         i, w_rsp_cyc, w_rsp_err, w_rsp_data, w_cs_cnt, w_rsp_cnt);
            else passed++;
        end
    endtask

    task automatic test_range;
        run_req(1'b1, 2'b10, 1'b0, 32'hCC, 32'h1111_2222);
`ifdef LSU_RANGE_CHK_EN
        total++;
        if (w_rsp_cyc != 1 || w_rsp_err !== 1'b1 || w_cs_cnt != 0)
            $display("FAIL range_err cyc=%0d err=%b cs_cnt=%0d want=1/1/0", w_rsp_cyc, w_rsp_err, w_cs_cnt);
        else passed++;
`else
        total++;
        if (w_wr_cyc != 1 || w_wr_addr !== 32'd51 || w_rsp_cyc != 2 || w_rsp_err !== 1'b0)
            $display("FAIL range_open wr_cyc=%0d addr=%0d rsp_cyc=%0d err=%b want=1/51/2/0",
                     w_wr_cyc, w_wr_addr, w_rsp_cyc, w_rsp_err);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid_op;
        int wr_seen;
        int rsp_seen;
        wr_seen = 0; rsp_seen = 0;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h8;
        req_wdata = 32'h0000_00A5; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (!(cs && rd)) $display("FAIL mid_rd cs=%b rd=%b want=1/1", cs, rd); else passed++;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b1 || cs !== 1'b0 || wr !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL mid_reset ready=%b cs=%b wr=%b rsp=%b want=1/0/0/0", req_ready, cs, wr, rsp_valid);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (wr) wr_seen++;
            if (rsp_valid) rsp_seen++;
        end
        total++;
        if (wr_seen != 0 || rsp_seen != 0)
            $display("FAIL mid_quiet wr=%0d rsp=%0d want=0/0", wr_seen, rsp_seen);
        else passed++;
        run_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        total++;
        if (w_rsp_cyc != 3 || w_rsp_data !== 32'h8081_5AF3)
            $display("FAIL mid_unchanged cyc=%0d data=%h want=3/80815af3", w_rsp_cyc, w_rsp_data);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        DB_r = 32'h0;
        test_reset;
        test_word_store_load;
        test_subword_loads;
        test_byte_store;
        test_half_store;
        test_errors;
        test_range;
        test_reset_mid_op;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
